// File: rtl/mult32_seq_pkg.sv
// Shared widths, iteration bound, state encoding and operand magnitude helper
// for the sequential 32x32 multiplier.
package mult32_seq_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int PROD_WIDTH = 64;
  localparam int CNT_WIDTH  = 6;
  localparam logic [CNT_WIDTH-1:0] ITER_LAST = 6'd31;

  // 2'b11 is unused and decodes back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  // 0x80000000 maps onto itself, which is its correct unsigned magnitude
  function automatic logic [MULT_WIDTH-1:0] mag32(input logic [MULT_WIDTH-1:0] x);
    return x[MULT_WIDTH-1] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mult32_acc_add.sv
// 64-bit add/subtract used for the accumulator update and, in subtract mode
// with a zero left operand, for the final two's-complement negation.
module mult32_acc_add
  import mult32_seq_pkg::*;
(
  input  logic [PROD_WIDTH-1:0] a,
  input  logic [PROD_WIDTH-1:0] b,
  input  logic                  sub,
  output logic [PROD_WIDTH-1:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/mult32_seq.sv
// Iterative shift-add 32x32->64 multiplier, one partial product per clock.
// MULT32_SEQ_SIGNED_EN selects two's-complement operands; default is unsigned.
//
// state | meaning
// IDLE  | waiting for START; captures operands on the accepting edge
// RUN   | 32 shift-add iterations, CNT 0..31
// FIX   | optional sign fix, HI/LO load, DONE pulse
module mult32_seq
  import mult32_seq_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [MULT_WIDTH-1:0] A,
  input  logic [MULT_WIDTH-1:0] B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [MULT_WIDTH-1:0] HI,
  output logic [MULT_WIDTH-1:0] LO
);

  state_t                  state_q, state_d;
  logic [PROD_WIDTH-1:0]   mcand_q;
  logic [MULT_WIDTH-1:0]   mult_q;
  logic [PROD_WIDTH-1:0]   acc_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [PROD_WIDTH-1:0]   prod_q;
  logic                    done_q;

  logic [PROD_WIDTH-1:0]   add_a, add_b, add_sum;
  logic                    add_sub;
  logic [PROD_WIDTH-1:0]   fix_val;
  logic [MULT_WIDTH-1:0]   a_mag, b_mag;

`ifdef MULT32_SEQ_SIGNED_EN
  logic sign_q;

  assign a_mag = mag32(A);
  assign b_mag = mag32(B);
`else
  assign a_mag = A;
  assign b_mag = B;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = RUN;
      RUN:     if (cnt_q == ITER_LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The adder is shared: accumulate in RUN, negate (0 - ACC) in FIX
  always_comb begin
    add_a   = acc_q;
    add_b   = mcand_q;
    add_sub = 1'b0;
`ifdef MULT32_SEQ_SIGNED_EN
    if (state_q == FIX) begin
      add_a   = '0;
      add_b   = acc_q;
      add_sub = 1'b1;
    end
`endif
  end

  mult32_acc_add u_acc_add (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_sum)
  );

`ifdef MULT32_SEQ_SIGNED_EN
  assign fix_val = sign_q ? add_sum : acc_q;
`else
  assign fix_val = acc_q;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
`ifdef MULT32_SEQ_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            mcand_q <= {{(PROD_WIDTH-MULT_WIDTH){1'b0}}, a_mag};
            mult_q  <= b_mag;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef MULT32_SEQ_SIGNED_EN
            sign_q  <= A[MULT_WIDTH-1] ^ B[MULT_WIDTH-1];
`endif
          end
        end
        RUN: begin
          if (mult_q[0]) acc_q <= add_sum;
          mcand_q <= mcand_q << 1;
          mult_q  <= mult_q >> 1;
          cnt_q   <= cnt_q + 6'd1;
        end
        FIX: begin
          prod_q <= fix_val;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state_q == RUN) || (state_q == FIX);
  assign DONE = done_q;
  assign HI   = prod_q[PROD_WIDTH-1:MULT_WIDTH];
  assign LO   = prod_q[MULT_WIDTH-1:0];

endmodule

// File: tb/tb_mult32_seq.sv
// Directed bench for mult32_seq: expected products are queued at START and
// compared when DONE pulses. Follows MULT32_SEQ_SIGNED_EN for its model.
module tb_mult32_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [31:0] A, B;
  logic        BUSY, DONE;
  logic [31:0] HI, LO;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  mult32_seq dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT32_SEQ_SIGNED_EN
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
`else
    return {32'b0, a} * {32'b0, b};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves START low one cycle after the accepting edge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    A = a;
    B = b;
    START = 1'b1;
    exp_q.push_back(model(a, b));
    @(negedge CLK);
    START = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_done(input string tag, input int exp_cycles);
    int n = 0;
    int busy_n = 0;
    logic [63:0] exp;
    while (DONE !== 1'b1 && n < 60) begin
      if (BUSY === 1'b1) busy_n++;
      @(negedge CLK);
      n++;
    end
    chk({tag, "_done"}, {63'b0, DONE}, 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(exp_cycles));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_cycles));
    chk({tag, "_busy_low"}, {63'b0, BUSY}, 64'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_hi"}, {32'b0, HI}, {32'b0, exp[63:32]});
      chk({tag, "_lo"}, {32'b0, LO}, {32'b0, exp[31:0]});
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    start_op(a, b);
    wait_done(tag, 33);
    @(negedge CLK);
    chk({tag, "_done_pulse"}, {63'b0, DONE}, 64'd0);
  endtask

  initial begin
    int dones;
    RESET = 1'b1;
    START = 1'b0;
    A = '0;
    B = '0;
    #12;
    chk("rst_busy", {63'b0, BUSY}, 64'd0);
    chk("rst_done", {63'b0, DONE}, 64'd0);
    chk("rst_hi", {32'b0, HI}, 64'd0);
    chk("rst_lo", {32'b0, LO}, 64'd0);
    @(negedge CLK);
    RESET = 1'b0;

    run_op("u3x5", 32'd3, 32'd5);
    chk("u3x5_const", {HI, LO}, 64'h0000_0000_0000_000F);
    run_op("neg3x5", 32'hFFFF_FFFD, 32'd5);
    run_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("minint", 32'h8000_0000, 32'h8000_0000);
    chk("minint_const", {HI, LO}, 64'h4000_0000_0000_0000);
    run_op("zero", 32'd0, 32'h1234_5678);
    run_op("rnd0", $urandom, $urandom);
    run_op("rnd1", $urandom, $urandom);

    // START while busy is ignored
    @(negedge CLK);
    start_op(32'd7, 32'd9);
    repeat (4) @(negedge CLK);
    A = 32'd1;
    B = 32'd1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done("busy_ign", 28);
    chk("busy_ign_const", {HI, LO}, 64'd63);

    // START during the DONE cycle is accepted
    start_op(32'd2, 32'd2);
    wait_done("done_start", 33);
    chk("done_start_const", {HI, LO}, 64'd4);

    // Reset mid-run aborts and clears outputs immediately
    @(negedge CLK);
    start_op(32'h0001_2345, 32'h0000_6789);
    repeat (9) @(negedge CLK);
    #1 RESET = 1'b1;
    #1;
    chk("abort_busy", {63'b0, BUSY}, 64'd0);
    chk("abort_done", {63'b0, DONE}, 64'd0);
    chk("abort_hi", {32'b0, HI}, 64'd0);
    chk("abort_lo", {32'b0, LO}, 64'd0);
    void'(exp_q.pop_back());
    @(negedge CLK);
    RESET = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE === 1'b1) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_idle", {63'b0, BUSY}, 64'd0);

    run_op("post_rst", 32'd6, 32'd7);
    chk("post_rst_const", {HI, LO}, 64'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
